// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: IF/ID register, register file with write-back bypass,
// RV32 subset decode, load-use hazard detection and the ID/EX output register.
module decode_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instruction,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stall_if,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_rs1_data,
   output logic [31:0] id_rs2_data,
   output logic [31:0] id_imm,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [4:0]  id_rd,
   output logic [3:0]  id_alu_op,
   output logic        id_alu_src,
   output logic        id_mem_read,
   output logic        id_mem_write,
   output logic        id_reg_write,
   output logic        id_illegal
);

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

   logic [31:0] regs [32];

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   alu_op_t     alu_op;
   logic        alu_src;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        illegal;
   logic        use_rs1;
   logic        use_rs2;
   logic [31:0] imm;
   logic        hazard;
   logic        issue;

   assign opcode = ifid_instr[6:0];
   assign rd     = ifid_instr[11:7];
   assign funct3 = ifid_instr[14:12];
   assign rs1    = ifid_instr[19:15];
   assign rs2    = ifid_instr[24:20];
   assign funct7 = ifid_instr[31:25];

   assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
   assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
   assign imm_u = {ifid_instr[31:12], 12'h000};

   // Write-back is forwarded so an instruction never reads a stale value being written this cycle.
   assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                     (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                     (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];

   always_comb begin
      alu_op    = ALU_ADD;
      alu_src   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      imm       = 32'd0;
      case (opcode)
         OP_R: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            reg_write = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: alu_op = ALU_ADD;
               10'b0100000_000: alu_op = ALU_SUB;
               10'b0000000_111: alu_op = ALU_AND;
               10'b0000000_110: alu_op = ALU_OR;
               10'b0000000_100: alu_op = ALU_XOR;
               10'b0000000_001: alu_op = ALU_SLL;
               10'b0000000_101: alu_op = ALU_SRL;
               10'b0100000_101: alu_op = ALU_SRA;
               10'b0000000_010: alu_op = ALU_SLT;
               10'b0000000_011: alu_op = ALU_SLTU;
               default:         illegal = 1'b1;
            endcase
         end
         OP_I: begin
            use_rs1   = 1'b1;
            alu_src   = 1'b1;
            reg_write = 1'b1;
            imm       = imm_i;
            case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b111: alu_op = ALU_AND;
               3'b110: alu_op = ALU_OR;
               3'b100: alu_op = ALU_XOR;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b001: begin
                  if (funct7 == 7'b0000000) alu_op = ALU_SLL;
                  else                      illegal = 1'b1;
               end
               default: begin
                  if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
                  else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                  else                           illegal = 1'b1;
               end
            endcase
         end
         OP_LOAD: begin
            use_rs1   = 1'b1;
            alu_src   = 1'b1;
            reg_write = 1'b1;
            mem_read  = 1'b1;
            imm       = imm_i;
            illegal   = (funct3 != 3'b010);
         end
         OP_STORE: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            alu_src   = 1'b1;
            mem_write = 1'b1;
            imm       = imm_s;
            illegal   = (funct3 != 3'b010);
         end
         OP_LUI: begin
            alu_op    = ALU_PASSB;
            alu_src   = 1'b1;
            reg_write = 1'b1;
            imm       = imm_u;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         alu_op    = ALU_ADD;
         alu_src   = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         use_rs1   = 1'b0;
         use_rs2   = 1'b0;
         imm       = 32'd0;
      end
      if (rd == 5'd0) reg_write = 1'b0;
   end

   // The load currently in ID/EX has not produced its data yet; its consumer must wait one cycle.
   assign hazard = id_valid && id_mem_read && (id_rd != 5'd0) && ifid_valid &&
                   ((use_rs1 && rs1 == id_rd) || (use_rs2 && rs2 == id_rd));
   assign stall_if = hazard && !flush;
   assign issue    = ifid_valid && !flush && !stall_if;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= 32'd0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= 32'd0;
      end else if (!stall_if) begin
         ifid_valid <= 1'b1;
         ifid_instr <= if_instruction;
         ifid_pc    <= if_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_we && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // A bubble zeroes every field so downstream stages never see stale operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid     <= 1'b0;
         id_pc        <= 32'd0;
         id_rs1_data  <= 32'd0;
         id_rs2_data  <= 32'd0;
         id_imm       <= 32'd0;
         id_rs1       <= 5'd0;
         id_rs2       <= 5'd0;
         id_rd        <= 5'd0;
         id_alu_op    <= 4'd0;
         id_alu_src   <= 1'b0;
         id_mem_read  <= 1'b0;
         id_mem_write <= 1'b0;
         id_reg_write <= 1'b0;
         id_illegal   <= 1'b0;
      end else begin
         id_valid     <= issue;
         id_pc        <= issue ? ifid_pc  : 32'd0;
         id_rs1_data  <= issue ? rs1_data : 32'd0;
         id_rs2_data  <= issue ? rs2_data : 32'd0;
         id_imm       <= issue ? imm      : 32'd0;
         id_rs1       <= issue ? rs1      : 5'd0;
         id_rs2       <= issue ? rs2      : 5'd0;
         id_rd        <= issue ? rd       : 5'd0;
         id_alu_op    <= issue ? alu_op   : 4'd0;
         id_alu_src   <= issue && alu_src;
         id_mem_read  <= issue && mem_read;
         id_mem_write <= issue && mem_write;
         id_reg_write <= issue && reg_write;
         id_illegal   <= issue && illegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Directed and randomized bench for decode_stage against an
// instruction-level pipeline model built from the generated instruction's meaning.
module tb_decode_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        illegal;
      logic        ck_rs1;
      logic        ck_rs2;
      logic        ck_rd;
      logic        ck_dat;
   } idex_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        uses1;
      logic        uses2;
      logic [4:0]  rs1f;
      logic [4:0]  rs2f;
      idex_t       d;
   } ins_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] if_pc = 32'd0;
   logic [31:0] if_instruction = NOP;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        stall_if;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [3:0]  id_alu_op;
   logic        id_alu_src;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_reg_write;
   logic        id_illegal;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mregs [32];
   ins_t        fetched;
   ins_t        held;
   idex_t       cur;
   logic        accepted = 1'b1;
   logic [31:0] pc_ctr = 32'd0;

   decode_stage #(.NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_instruction(if_instruction),
      .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_if(stall_if), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .id_illegal(id_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic idex_t bubble_rec();
      idex_t e;
      e.valid = 1'b0; e.pc = 32'd0; e.rs1_data = 32'd0; e.rs2_data = 32'd0; e.imm = 32'd0;
      e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0; e.alu_op = 4'd0; e.alu_src = 1'b0;
      e.mem_read = 1'b0; e.mem_write = 1'b0; e.reg_write = 1'b0; e.illegal = 1'b0;
      e.ck_rs1 = 1'b1; e.ck_rs2 = 1'b1; e.ck_rd = 1'b1; e.ck_dat = 1'b1;
      return e;
   endfunction

   // {funct7, funct3} of each ALU operation, indexed by its alu_op code.
   function automatic logic [9:0] f73(input int op);
      case (op)
         0: return {7'h00, 3'd0};
         1: return {7'h20, 3'd0};
         2: return {7'h00, 3'd7};
         3: return {7'h00, 3'd6};
         4: return {7'h00, 3'd4};
         5: return {7'h00, 3'd1};
         6: return {7'h00, 3'd5};
         7: return {7'h20, 3'd5};
         8: return {7'h00, 3'd2};
         default: return {7'h00, 3'd3};
      endcase
   endfunction

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return (v >= 12'd2048) ? 32'(v) - 32'd4096 : 32'(v);
   endfunction

   // kind 0-9: R-type op; 10-19: I-ALU op (11 folds to ADD); 20 LW; 21 SW; 22 LUI; else illegal.
   function automatic ins_t make_ins(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
      ins_t r;
      logic [9:0] ft;
      logic [11:0] i12;
      int op;
      r.pc = pc; r.valid = 1'b1; r.uses1 = 1'b0; r.uses2 = 1'b0; r.rs1f = rs1; r.rs2f = rs2;
      r.d = bubble_rec();
      r.d.valid = 1'b1; r.d.pc = pc; r.d.rs1 = rs1; r.d.rs2 = rs2; r.d.rd = rd;
      r.d.ck_rs1 = 1'b0; r.d.ck_rs2 = 1'b0; r.d.ck_rd = 1'b0;
      i12 = imm[11:0];
      if (kind < 10) begin
         ft = f73(kind);
         r.instr = {ft[9:3], rs2, rs1, ft[2:0], rd, 7'b0110011};
         r.d.alu_op = 4'(kind); r.d.reg_write = (rd != 5'd0);
         r.uses1 = 1'b1; r.uses2 = 1'b1; r.d.ck_rs1 = 1'b1; r.d.ck_rs2 = 1'b1; r.d.ck_rd = 1'b1;
      end else if (kind < 20) begin
         op = (kind == 11) ? 0 : kind - 10;
         ft = f73(op);
         if (op >= 5 && op <= 7) i12 = {ft[9:3], imm[4:0]};
         r.instr = {i12, rs1, ft[2:0], rd, 7'b0010011};
         r.d.alu_op = 4'(op); r.d.alu_src = 1'b1; r.d.reg_write = (rd != 5'd0); r.d.imm = sext12(i12);
         r.uses1 = 1'b1; r.d.ck_rs1 = 1'b1; r.d.ck_rd = 1'b1;
      end else if (kind == 20) begin
         r.instr = {i12, rs1, 3'b010, rd, 7'b0000011};
         r.d.alu_src = 1'b1; r.d.mem_read = 1'b1; r.d.reg_write = (rd != 5'd0); r.d.imm = sext12(i12);
         r.uses1 = 1'b1; r.d.ck_rs1 = 1'b1; r.d.ck_rd = 1'b1;
      end else if (kind == 21) begin
         r.instr = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
         r.d.alu_src = 1'b1; r.d.mem_write = 1'b1; r.d.imm = sext12(i12);
         r.uses1 = 1'b1; r.uses2 = 1'b1; r.d.ck_rs1 = 1'b1; r.d.ck_rs2 = 1'b1;
      end else if (kind == 22) begin
         r.instr = {imm[19:0], rd, 7'b0110111};
         r.d.alu_op = 4'd10; r.d.alu_src = 1'b1; r.d.reg_write = (rd != 5'd0);
         r.d.imm = {imm[19:0], 12'h000}; r.d.ck_rd = 1'b1;
      end else begin
         r.instr = {imm[24:0], 7'h7F};
         r.d.illegal = 1'b1; r.d.ck_dat = 1'b0;
      end
      return r;
   endfunction

   function automatic ins_t rand_ins(input logic [31:0] pc);
      int kind;
      kind = $urandom_range(0, 27);
      if (kind > 23) kind = 20;
      return make_ins(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), $urandom, pc);
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_we && wb_rd == r) return wb_data;
      return mregs[r];
   endfunction

   function automatic ins_t nop_ins();
      ins_t n;
      n = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      n.valid = 1'b0; n.instr = NOP;
      return n;
   endfunction

   task automatic compare_id(input idex_t e);
      chk("id_valid", 32'(id_valid), 32'(e.valid));
      chk("id_alu_op", 32'(id_alu_op), 32'(e.alu_op));
      chk("id_alu_src", 32'(id_alu_src), 32'(e.alu_src));
      chk("id_mem_read", 32'(id_mem_read), 32'(e.mem_read));
      chk("id_mem_write", 32'(id_mem_write), 32'(e.mem_write));
      chk("id_reg_write", 32'(id_reg_write), 32'(e.reg_write));
      chk("id_illegal", 32'(id_illegal), 32'(e.illegal));
      if (e.ck_dat) begin
         chk("id_pc", id_pc, e.pc);
         chk("id_imm", id_imm, e.imm);
      end
      if (e.ck_rs1) begin
         chk("id_rs1", 32'(id_rs1), 32'(e.rs1));
         chk("id_rs1_data", id_rs1_data, e.rs1_data);
      end
      if (e.ck_rs2) begin
         chk("id_rs2", 32'(id_rs2), 32'(e.rs2));
         chk("id_rs2_data", id_rs2_data, e.rs2_data);
      end
      if (e.ck_rd) chk("id_rd", 32'(id_rd), 32'(e.rd));
   endtask

   // One clock: present fetched + wb + flush, predict stall and the next ID/EX contents.
   task automatic cycle();
      logic  st;
      idex_t nx;
      if_pc = fetched.pc;
      if_instruction = fetched.instr;
      st = !flush && cur.valid && cur.mem_read && cur.rd != 5'd0 && held.valid &&
           ((held.uses1 && held.rs1f == cur.rd) || (held.uses2 && held.rs2f == cur.rd));
      #1;
      chk("stall_if", 32'(stall_if), 32'(st));
      nx = bubble_rec();
      if (!flush && !st && held.valid) begin
         nx = held.d;
         nx.rs1_data = model_read(held.rs1f);
         nx.rs2_data = model_read(held.rs2f);
      end
      if (flush) held = nop_ins();
      else if (!st) held = fetched;
      if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
      @(posedge clk);
      #1;
      cur = nx;
      accepted = !st;
      compare_id(cur);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      held = nop_ins();
      cur = bubble_rec();
      #1;
      chk("rst_stall_if", 32'(stall_if), 32'd0);
      compare_id(cur);
      chk("rst_ifid_valid", 32'(dut.ifid_valid), 32'd0);
      chk("rst_ifid_instr", dut.ifid_instr, NOP);
      chk("rst_ifid_pc", dut.ifid_pc, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      do_reset();

      // ADDI x1,x0,5 at pc 0 reaches ID/EX two edges later.
      fetched = make_ins(10, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0);
      cycle();
      fetched = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd4);
      cycle();
      chk("addi_valid", 32'(id_valid), 32'd1);
      chk("addi_imm", id_imm, 32'd5);
      chk("addi_op", 32'(id_alu_op), 32'd0);
      chk("addi_src", 32'(id_alu_src), 32'd1);
      chk("addi_rw", 32'(id_reg_write), 32'd1);
      chk("addi_rd", 32'(id_rd), 32'd1);

      // Write-back bypass, then x0 stays zero despite a write to it.
      fetched = make_ins(0, 5'd4, 5'd3, 5'd0, 32'd0, 32'd8);
      cycle();
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
      fetched = make_ins(0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd12);
      cycle();
      chk("bypass_rs1", id_rs1_data, 32'hDEAD_BEEF);
      wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      fetched = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd16);
      cycle();
      chk("x0_rs1", id_rs1_data, 32'd0);
      wb_we = 1'b0;

      // LW x2,0(x1) then ADD x5,x2,x2: one stall, one bubble, then ADD.
      fetched = make_ins(20, 5'd2, 5'd1, 5'd0, 32'd0, 32'd20);
      cycle();
      fetched = make_ins(0, 5'd5, 5'd2, 5'd2, 32'd0, 32'd24);
      cycle();
      chk("lu_stall", 32'(stall_if), 32'd1);
      fetched = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd28);
      cycle();
      chk("lu_bubble", 32'(id_valid), 32'd0);
      chk("lu_stall_end", 32'(stall_if), 32'd0);
      cycle();
      chk("lu_add_valid", 32'(id_valid), 32'd1);
      chk("lu_add_rs1", 32'(id_rs1), 32'd2);
      chk("lu_add_rs2", 32'(id_rs2), 32'd2);

      // Flush while a SW with a pending load-use hazard sits in IF/ID.
      fetched = make_ins(20, 5'd2, 5'd1, 5'd0, 32'd4, 32'd32);
      cycle();
      fetched = make_ins(21, 5'd0, 5'd1, 5'd2, 32'd8, 32'd36);
      cycle();
      chk("sw_hazard", 32'(stall_if), 32'd1);
      flush = 1'b1;
      fetched = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd40);
      cycle();
      flush = 1'b0;
      chk("fl_valid", 32'(id_valid), 32'd0);
      chk("fl_ifid_instr", dut.ifid_instr, NOP);
      chk("fl_ifid_valid", 32'(dut.ifid_valid), 32'd0);

      // Illegal opcode 0x7F and LUI x7,0x12345.
      fetched = make_ins(23, 5'd0, 5'd0, 5'd0, 32'h0123_4567, 32'd44);
      cycle();
      fetched = make_ins(22, 5'd7, 5'd0, 5'd0, 32'h0001_2345, 32'd48);
      cycle();
      chk("ill_illegal", 32'(id_illegal), 32'd1);
      chk("ill_valid", 32'(id_valid), 32'd1);
      chk("ill_rw", 32'(id_reg_write), 32'd0);
      fetched = make_ins(10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd52);
      cycle();
      chk("lui_imm", id_imm, 32'h1234_5000);
      chk("lui_op", 32'(id_alu_op), 32'd10);

      // Randomized stream with random write-back and occasional flushes.
      pc_ctr = 32'd100;
      for (int n = 0; n < 600; n++) begin
         if (accepted) begin
            fetched = rand_ins(pc_ctr);
            pc_ctr += 32'd4;
         end
         wb_we = 1'($urandom_range(0, 1));
         wb_rd = 5'($urandom_range(0, 4));
         wb_data = $urandom;
         flush = ($urandom_range(0, 15) == 0);
         cycle();
      end
      wb_we = 1'b0;
      flush = 1'b0;

      // Reset in the middle of a load-use stall.
      fetched = make_ins(20, 5'd1, 5'd2, 5'd0, 32'd0, 32'd200);
      cycle();
      fetched = make_ins(0, 5'd6, 5'd1, 5'd3, 32'd0, 32'd204);
      cycle();
      chk("rs_stall", 32'(stall_if), 32'd1);
      #2;
      do_reset();
      fetched = make_ins(0, 5'd6, 5'd3, 5'd1, 32'd0, 32'd0);
      cycle();
      fetched = make_ins(0, 5'd7, 5'd2, 5'd4, 32'd0, 32'd4);
      cycle();
      chk("rs_x3_zero", id_rs1_data, 32'd0);
      chk("rs_x1_zero", id_rs2_data, 32'd0);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
